// File: rtl/pattern_seq_gen.sv
// Streams a DEPTH-element packed PATTERN over valid/ready, one-shot or looping; optional PATGEN_PASSCNT_EN adds pass_cnt_o.
// Latency: first element is valid the cycle after an accepted start_i; one element per cycle after that, no bubble on wrap.
// Backpressure: with ready_i low, data_o/idx_o/last_o hold; stop_i ends looping at the next pass boundary.
module pattern_seq_gen #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [DEPTH*WIDTH-1:0] PATTERN = {32'd3, 32'd3, 32'd3, 32'd3},
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             loop_i,
  input  logic             stop_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o,
  output logic [IDXW-1:0]  idx_o,
  output logic             busy_o,
`ifdef PATGEN_PASSCNT_EN
  output logic [15:0]      pass_cnt_o,
`endif
  output logic             done_o
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  logic            loop_q;
  logic            stop_pend;
  logic            xfer;
  logic            at_last;
  logic            end_seq;
  logic [IDXW-1:0] nxt_idx;

  // Element k lives at bits [k*WIDTH +: WIDTH]; callers only pass in-range indices.
  function automatic logic [WIDTH-1:0] elem(input logic [IDXW-1:0] k);
    return PATTERN[int'(k)*WIDTH +: WIDTH];
  endfunction

  // Handshake and pass-boundary decode; index advance is an explicit compare so
  // non-power-of-two DEPTH never steps past LAST_IDX.
  always_comb begin
    xfer    = 1'b0;
    at_last = 1'b0;
    end_seq = 1'b0;
    nxt_idx = '0;
    xfer    = (state == RUN) && valid_o && ready_i;
    at_last = (idx_o == LAST_IDX);
    // A stop arriving with the final transfer still ends this pass.
    end_seq = !loop_q || stop_pend || stop_i;
    nxt_idx = at_last ? '0 : (idx_o + 1'b1);
  end

  // Control FSM with registered outputs; done_o defaults low so it pulses once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid_o   <= 1'b0;
      data_o    <= '0;
      last_o    <= 1'b0;
      idx_o     <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      loop_q    <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          // stop_i has no meaning before a sequence exists.
          if (start_i) begin
            state     <= RUN;
            valid_o   <= 1'b1;
            busy_o    <= 1'b1;
            idx_o     <= '0;
            data_o    <= elem('0);
            last_o    <= (LAST_IDX == '0);
            loop_q    <= loop_i;
            stop_pend <= 1'b0;
          end
        end
        RUN: begin
          // start_i is deliberately ignored while a sequence is running.
          if (stop_i) begin
            stop_pend <= 1'b1;
          end
          if (xfer) begin
            if (at_last && end_seq) begin
              // data_o and idx_o keep the final element for observation.
              state     <= IDLE;
              valid_o   <= 1'b0;
              busy_o    <= 1'b0;
              last_o    <= 1'b0;
              done_o    <= 1'b1;
              stop_pend <= 1'b0;
              loop_q    <= 1'b0;
            end else begin
              idx_o  <= nxt_idx;
              data_o <= elem(nxt_idx);
              last_o <= (nxt_idx == LAST_IDX);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef PATGEN_PASSCNT_EN
  // Completed-pass counter: cleared on reset and accepted start, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_cnt_o <= '0;
    end else if ((state == IDLE) && start_i) begin
      pass_cnt_o <= '0;
    end else if (xfer && at_last && (pass_cnt_o != 16'hFFFF)) begin
      pass_cnt_o <= pass_cnt_o + 16'd1;
    end
  end
`endif

endmodule
